chip_test_sequencer: RTL and testbench
======================================

Name: chip_test_sequencer

Overview:
- Front-end controller for the chip-checker tester modules, such as the per-part shift-register testers.
- Latches the operator's part selection and launches exactly one tester via Run.
- Routes that tester's socket-drive pins to the physical socket and captures its Done/RSLT verdict.
- Releases the tester through DISP_RSLT when the operator acknowledges, so only one tester can drive the socket at a time.

Parameters:
- NUM_CHIPS, 8, number of tester modules attached (1..2^SEL_W).
- SEL_W, 3, width of the part-select switch field.
- PIN_W, 16, width of each tester's socket-drive pin bus.
- TIMEOUT_CYCLES, 4096, watchdog limit in WAIT_DONE (used only with the optional feature).

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  operator start, level; acted on at its rising edge only.
- Ack  in  1  operator acknowledge, level; acted on at its rising edge only.
- Sel  in  SEL_W  part select; sampled on the Start edge.
- chip_done  in  NUM_CHIPS  Done from each tester.
- chip_rslt  in  NUM_CHIPS  RSLT from each tester.
- chip_pins  in  NUM_CHIPS*PIN_W  tester k drive bus at bits [k*PIN_W +: PIN_W].
- chip_run  out  NUM_CHIPS  Run to each tester.
- chip_disp  out  NUM_CHIPS  DISP_RSLT to each tester.
- socket_out  out  PIN_W  muxed drive to the socket.
- Busy  out  1  high whenever state is not IDLE.
- Pass  out  1  verdict: pass.
- Fail  out  1  verdict: fail.
- Invalid  out  1  Sel was >= NUM_CHIPS.
- Timeout  out  1  watchdog expired (optional feature only).
- cur_sel  out  SEL_W  latched selection.

Behaviour:
- Reset (synchronous, active-high, clock Clk):
  - State goes to IDLE.
  - All outputs are 0 and cur_sel = 0.
  - Edge-detect history registers load the current Start/Ack levels, so a button held through reset does not trigger.
  - Reset mid-test abandons the tester. The tester is not released; it self-recovers on its own Reset.
- States: IDLE, LAUNCH, WAIT_DONE, RESULT, RELEASE.
- IDLE:
  - On a Start rising edge, latch Sel into cur_sel and clear Pass, Fail, Invalid and Timeout.
  - If Sel >= NUM_CHIPS: set Fail=1 and Invalid=1, go to RESULT.
  - Otherwise go to LAUNCH.
- LAUNCH: chip_run[cur_sel]=1 for exactly one cycle, then go to WAIT_DONE.
- WAIT_DONE:
  - Watch chip_done[cur_sel] with a two-cycle qualifier.
  - On the 2nd consecutive cycle it is high, sample chip_rslt[cur_sel]: 1 gives Pass=1, 0 gives Fail=1. Go to RESULT.
  - The qualifier is required because a tester raises Done one cycle before its RSLT register settles.
  - Start edges are ignored in this state.
- RESULT:
  - Pass, Fail and Invalid are held.
  - On an Ack rising edge, pulse chip_disp[cur_sel] for one cycle (suppressed when Invalid=1), then go to RELEASE.
  - Start edges are ignored in this state.
- RELEASE:
  - Go to IDLE once chip_done[cur_sel]==0.
  - Go to IDLE immediately if Invalid or Timeout is set.
  - Pass/Fail remain visible in IDLE until the next Start.
- socket_out:
  - Equals chip_pins[cur_sel] in LAUNCH, WAIT_DONE and RESULT.
  - Is 0 in IDLE and RELEASE, and 0 whenever Invalid=1.
  - This output is registered, so it lags the state by one cycle.
- chip_run and chip_disp are one-hot or zero. At most one bit is high in any cycle.
- Start and Ack arriving in the same cycle: in IDLE, Start wins; in RESULT, Ack wins.
- Pass and Fail are never both high.

Optional Feature:
- Macro: CHIP_SEQ_TIMEOUT_EN.
- When defined:
  - A counter of width $clog2(TIMEOUT_CYCLES)+1 clears on entry to WAIT_DONE and increments each cycle there.
  - On reaching TIMEOUT_CYCLES, set Fail=1 and Timeout=1, go to RESULT.
  - Ack in this case still pulses chip_disp, and RELEASE exits immediately.
- When undefined: no counter exists, the Timeout port is tied 0, and WAIT_DONE waits indefinitely.

Test Plan:
1. Reset, Sel=2, Start edge; tester 2 holds Done high from cycle 10 with RSLT=1 -> chip_run=3'b100 pulse for 1 cycle; Pass=1 two cycles after Done rises; socket_out tracks chip_pins[2].
2. Same as 1 but RSLT=0 -> Fail=1, Pass=0; Ack edge -> chip_disp[2] pulses for 1 cycle; after Done drops, Busy=0 and Fail is still 1.
3. Done high for only 1 cycle, then high again later -> no sample on the single-cycle blip; sampled on the later 2-cycle run.
4. NUM_CHIPS=5, Sel=6, Start -> Invalid=1, Fail=1, no chip_run bit, socket_out=0; Ack -> IDLE with no chip_disp pulse.
5. CHIP_SEQ_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, tester never raises Done -> Timeout=1, Fail=1 exactly 16 cycles after entering WAIT_DONE.
6. Reset asserted in WAIT_DONE with Start held high -> all outputs 0 next cycle; no relaunch until Start is released and pressed again.

Source files
------------

// File: rtl/chip_test_sequencer.sv
// rtl/chip_test_sequencer.sv - launches one chip tester, routes its socket pins and captures its verdict
// Define CHIP_SEQ_TIMEOUT_EN to add the WAIT_DONE watchdog; otherwise Timeout is tied 0.
module chip_test_sequencer #(
  parameter int NUM_CHIPS      = 8,
  parameter int SEL_W          = 3,
  parameter int PIN_W          = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       Start,
  input  logic                       Ack,
  input  logic [SEL_W-1:0]           Sel,
  input  logic [NUM_CHIPS-1:0]       chip_done,
  input  logic [NUM_CHIPS-1:0]       chip_rslt,
  input  logic [NUM_CHIPS*PIN_W-1:0] chip_pins,
  output logic [NUM_CHIPS-1:0]       chip_run,
  output logic [NUM_CHIPS-1:0]       chip_disp,
  output logic [PIN_W-1:0]           socket_out,
  output logic                       Busy,
  output logic                       Pass,
  output logic                       Fail,
  output logic                       Invalid,
  output logic                       Timeout,
  output logic [SEL_W-1:0]           cur_sel
);
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_DONE, RESULT, RELEASE} state_e;

  state_e           state_q, state_d;
  logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
  logic             pass_q, pass_d, fail_q, fail_d;
  logic             invalid_q, invalid_d, timeout_q, timeout_d;
  logic             qual_q, qual_d;
  logic             start_prev_q, start_prev_d, ack_prev_q, ack_prev_d;
  logic [PIN_W-1:0] socket_q, socket_d;
  logic             start_rise, ack_rise, wd_expired;
  logic             done_sel, rslt_sel;
  logic [PIN_W-1:0] pins_sel;

  assign start_rise = Start & ~start_prev_q;
  assign ack_rise   = Ack & ~ack_prev_q;

  // Out-of-range selections read as an absent tester: Done, RSLT and pins all 0.
  always_comb begin
    done_sel = 1'b0;
    rslt_sel = 1'b0;
    pins_sel = '0;
    for (int k = 0; k < NUM_CHIPS; k++) begin
      if (int'(cur_sel_q) == k) begin
        done_sel = chip_done[k];
        rslt_sel = chip_rslt[k];
        pins_sel = chip_pins[k*PIN_W +: PIN_W];
      end
    end
  end

`ifdef CHIP_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;

  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (state_q == LAUNCH)
      wd_cnt_d = '0;
    else if (state_q == WAIT_DONE)
      wd_cnt_d = wd_cnt_q + CNT_W'(1);
  end

  assign wd_expired = (state_q == WAIT_DONE) && (wd_cnt_d == CNT_W'(TIMEOUT_CYCLES));
`else
  assign wd_expired = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= IDLE;
      cur_sel_q    <= '0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      invalid_q    <= 1'b0;
      timeout_q    <= 1'b0;
      qual_q       <= 1'b0;
      socket_q     <= '0;
      start_prev_q <= Start;
      ack_prev_q   <= Ack;
    end else begin
      state_q      <= state_d;
      cur_sel_q    <= cur_sel_d;
      pass_q       <= pass_d;
      fail_q       <= fail_d;
      invalid_q    <= invalid_d;
      timeout_q    <= timeout_d;
      qual_q       <= qual_d;
      socket_q     <= socket_d;
      start_prev_q <= start_prev_d;
      ack_prev_q   <= ack_prev_d;
    end
`ifdef CHIP_SEQ_TIMEOUT_EN
    wd_cnt_q <= Reset ? '0 : wd_cnt_d;
`endif
  end

  always_comb begin
    state_d      = state_q;
    cur_sel_d    = cur_sel_q;
    pass_d       = pass_q;
    fail_d       = fail_q;
    invalid_d    = invalid_q;
    timeout_d    = timeout_q;
    qual_d       = 1'b0;
    start_prev_d = Start;
    ack_prev_d   = Ack;
    case (state_q)
      IDLE: begin
        if (start_rise) begin
          cur_sel_d = Sel;
          pass_d    = 1'b0;
          fail_d    = 1'b0;
          invalid_d = 1'b0;
          timeout_d = 1'b0;
          if (int'(Sel) >= NUM_CHIPS) begin
            fail_d    = 1'b1;
            invalid_d = 1'b1;
            state_d   = RESULT;
          end else begin
            state_d = LAUNCH;
          end
        end
      end
      LAUNCH: state_d = WAIT_DONE;
      WAIT_DONE: begin
        // Done leads RSLT by a cycle, so RSLT is taken on Done's second high cycle.
        qual_d = done_sel;
        if (done_sel && qual_q) begin
          pass_d  = rslt_sel;
          fail_d  = ~rslt_sel;
          state_d = RESULT;
        end else if (wd_expired) begin
          fail_d    = 1'b1;
          timeout_d = 1'b1;
          state_d   = RESULT;
        end
      end
      RESULT: if (ack_rise) state_d = RELEASE;
      RELEASE: if (invalid_q || timeout_q || !done_sel) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    socket_d = ((state_q == LAUNCH || state_q == WAIT_DONE || state_q == RESULT) && !invalid_q)
               ? pins_sel : '0;
  end

  always_comb begin
    chip_run  = '0;
    chip_disp = '0;
    for (int k = 0; k < NUM_CHIPS; k++) begin
      if (int'(cur_sel_q) == k) begin
        chip_run[k]  = (state_q == LAUNCH);
        chip_disp[k] = (state_q == RESULT) && ack_rise && !invalid_q;
      end
    end
    Busy       = (state_q != IDLE);
    Pass       = pass_q;
    Fail       = fail_q;
    Invalid    = invalid_q;
    Timeout    = timeout_q;
    cur_sel    = cur_sel_q;
    socket_out = socket_q;
  end
endmodule

// File: tb/tb_chip_test_sequencer.sv
// tb/tb_chip_test_sequencer.sv - scoreboard bench for chip_test_sequencer (5 testers, 16-cycle watchdog)
`timescale 1ns/1ps
module tb_chip_test_sequencer;
  localparam int NC = 5;
  localparam int SW = 3;
  localparam int PW = 16;
  localparam int TO = 16;

  logic          Clk = 1'b0, Reset = 1'b1, Start = 1'b0, Ack = 1'b0;
  logic [SW-1:0] Sel = '0;
  logic [NC-1:0] chip_done = '0, chip_rslt = '0;
  logic [NC*PW-1:0] chip_pins = '0;
  logic [NC-1:0] chip_run, chip_disp;
  logic [PW-1:0] socket_out;
  logic          Busy, Pass, Fail, Invalid, Timeout;
  logic [SW-1:0] cur_sel;

  chip_test_sequencer #(.NUM_CHIPS(NC), .SEL_W(SW), .PIN_W(PW), .TIMEOUT_CYCLES(TO)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack), .Sel(Sel),
    .chip_done(chip_done), .chip_rslt(chip_rslt), .chip_pins(chip_pins),
    .chip_run(chip_run), .chip_disp(chip_disp), .socket_out(socket_out),
    .Busy(Busy), .Pass(Pass), .Fail(Fail), .Invalid(Invalid), .Timeout(Timeout), .cur_sel(cur_sel)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [SW-1:0] sel;
    logic          pass;
    logic          fail;
    logic          invalid;
    logic          timeout;
  } verdict_t;

  verdict_t exp_q[$];
  verdict_t e;
  int n_checks = 0, n_fail = 0;
  int run_pulses = 0, disp_pulses = 0, exp_runs = 0, exp_disps = 0, multi_hot = 0;
  int lat;

  always @(negedge Clk) begin
    #3;
    if ($countones(chip_run) > 1 || $countones(chip_disp) > 1 || (chip_run != 0 && chip_disp != 0))
      multi_hot++;
    if (chip_run != 0) run_pulses++;
    if (chip_disp != 0) disp_pulses++;
  end

  task automatic step();
    @(negedge Clk);
    #1;
  endtask

  task automatic set_pins();
    for (int k = 0; k < NC; k++) chip_pins[k*PW +: PW] = 16'($urandom);
  endtask

  task automatic wait_verdict();
    lat = 0;
    while (!(Pass || Fail) && lat < 100) begin
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start = 1'b1; Ack = 1'b1;
    step(); step();
    n_checks++;
    if ({chip_run, chip_disp, socket_out, Busy, Pass, Fail, Invalid, Timeout, cur_sel} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0",
               {chip_run, chip_disp, socket_out, Busy, Pass, Fail, Invalid, Timeout, cur_sel});
    end
    Reset = 1'b0;
    step();
    n_checks++;
    if (Busy !== 1'b0) begin n_fail++; $display("FAIL held_start_ignored: Busy=%b expected 0", Busy); end
    Start = 1'b0; Ack = 1'b0;
    step();
  endtask

  task automatic test_pass();
    set_pins(); chip_rslt = 5'b00100; chip_done = '0;
    exp_q.push_back({3'd2, 1'b1, 1'b0, 1'b0, 1'b0});
    exp_runs++;
    Sel = 3'd2; Start = 1'b1;
    step();
    Start = 1'b0;
    n_checks++;
    if ({chip_run, Busy, cur_sel} !== {5'b00100, 1'b1, 3'd2}) begin
      n_fail++; $display("FAIL run_launch: run=%b busy=%b sel=%0d expected 00100/1/2", chip_run, Busy, cur_sel);
    end
    step();
    n_checks++;
    if (chip_run !== 5'b0) begin n_fail++; $display("FAIL run_one_cycle: got %b expected 0", chip_run); end
    n_checks++;
    if (socket_out !== chip_pins[2*PW +: PW]) begin
      n_fail++; $display("FAIL socket_wait: got %h expected %h", socket_out, chip_pins[2*PW +: PW]);
    end
    repeat (6) step();
    chip_pins[2*PW +: PW] = 16'hBEEF;
    step();
    n_checks++;
    if (socket_out !== 16'hBEEF) begin n_fail++; $display("FAIL socket_track: got %h expected beef", socket_out); end
    chip_done[2] = 1'b1;
    wait_verdict();
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("FAIL pass_latency: got %0d expected 2", lat); end
    n_checks++;
    e = exp_q.pop_front();
    if ({cur_sel, Pass, Fail, Invalid, Timeout} !== e) begin
      n_fail++; $display("FAIL pass_verdict: got %b expected %b", {cur_sel, Pass, Fail, Invalid, Timeout}, e);
    end
    n_checks++;
    if (socket_out !== 16'hBEEF) begin n_fail++; $display("FAIL socket_result: got %h expected beef", socket_out); end
    Ack = 1'b1; exp_disps++;
    #1;
    n_checks++;
    if (chip_disp !== 5'b00100) begin n_fail++; $display("FAIL pass_disp: got %b expected 00100", chip_disp); end
    step();
    Ack = 1'b0;
    n_checks++;
    if (chip_disp !== 5'b0 || Busy !== 1'b1) begin
      n_fail++; $display("FAIL release_hold: disp=%b busy=%b expected 0/1", chip_disp, Busy);
    end
    chip_done[2] = 1'b0;
    step();
    n_checks++;
    if ({Busy, Pass, Fail, socket_out} !== {1'b0, 1'b1, 1'b0, 16'h0}) begin
      n_fail++; $display("FAIL pass_idle: busy=%b pass=%b fail=%b sock=%h expected 0/1/0/0", Busy, Pass, Fail, socket_out);
    end
  endtask

  task automatic test_fail();
    set_pins(); chip_rslt = 5'b11011; chip_done = '0;
    exp_q.push_back({3'd2, 1'b0, 1'b1, 1'b0, 1'b0});
    exp_runs++;
    Sel = 3'd2; Start = 1'b1;
    step();
    Start = 1'b0;
    step();
    Sel = 3'd0; Start = 1'b1;
    step();
    Start = 1'b0;
    n_checks++;
    if ({Busy, cur_sel, Pass, Fail} !== {1'b1, 3'd2, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL start_ignored_wait: busy=%b sel=%0d expected 1/2", Busy, cur_sel);
    end
    chip_done[2] = 1'b1;
    wait_verdict();
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("FAIL fail_latency: got %0d expected 2", lat); end
    n_checks++;
    e = exp_q.pop_front();
    if ({cur_sel, Pass, Fail, Invalid, Timeout} !== e) begin
      n_fail++; $display("FAIL fail_verdict: got %b expected %b", {cur_sel, Pass, Fail, Invalid, Timeout}, e);
    end
    Ack = 1'b1; exp_disps++;
    #1;
    n_checks++;
    if (chip_disp !== 5'b00100) begin n_fail++; $display("FAIL fail_disp: got %b expected 00100", chip_disp); end
    step();
    Ack = 1'b0;
    chip_done[2] = 1'b0;
    step();
    n_checks++;
    if ({Busy, Pass, Fail} !== 3'b001) begin
      n_fail++; $display("FAIL fail_idle: busy/pass/fail=%b expected 001", {Busy, Pass, Fail});
    end
  endtask

  task automatic test_glitch();
    set_pins(); chip_rslt = 5'b00010; chip_done = '0;
    exp_q.push_back({3'd1, 1'b1, 1'b0, 1'b0, 1'b0});
    exp_runs++;
    Sel = 3'd1; Start = 1'b1;
    step();
    Start = 1'b0;
    step();
    chip_done[1] = 1'b1;
    step();
    chip_done[1] = 1'b0;
    repeat (3) step();
    n_checks++;
    if ({Busy, Pass, Fail} !== 3'b100) begin
      n_fail++; $display("FAIL glitch_ignored: busy/pass/fail=%b expected 100", {Busy, Pass, Fail});
    end
    chip_done[1] = 1'b1;
    wait_verdict();
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("FAIL glitch_latency: got %0d expected 2", lat); end
    n_checks++;
    e = exp_q.pop_front();
    if ({cur_sel, Pass, Fail, Invalid, Timeout} !== e) begin
      n_fail++; $display("FAIL glitch_verdict: got %b expected %b", {cur_sel, Pass, Fail, Invalid, Timeout}, e);
    end
    Start = 1'b1; Ack = 1'b1; exp_disps++;
    #1;
    n_checks++;
    if (chip_disp !== 5'b00010) begin n_fail++; $display("FAIL ack_wins: got %b expected 00010", chip_disp); end
    step();
    Ack = 1'b0;
    n_checks++;
    if ({Busy, cur_sel} !== {1'b1, 3'd1}) begin
      n_fail++; $display("FAIL release_wait_done: busy=%b sel=%0d expected 1/1", Busy, cur_sel);
    end
    chip_done[1] = 1'b0;
    step(); step();
    n_checks++;
    if ({Busy, Pass} !== 2'b01) begin
      n_fail++; $display("FAIL no_stale_start: busy/pass=%b expected 01", {Busy, Pass});
    end
    Start = 1'b0;
    step();
  endtask

  task automatic test_invalid();
    logic [SW-1:0] tbl [3] = '{3'd5, 3'd6, 3'd7};
    chip_done = '1;
    foreach (tbl[i]) begin
      exp_q.push_back({tbl[i], 1'b0, 1'b1, 1'b1, 1'b0});
      Sel = tbl[i]; Start = 1'b1;
      step();
      Start = 1'b0;
      n_checks++;
      e = exp_q.pop_front();
      if ({cur_sel, Pass, Fail, Invalid, Timeout} !== e) begin
        n_fail++; $display("FAIL invalid_verdict: got %b expected %b", {cur_sel, Pass, Fail, Invalid, Timeout}, e);
      end
      step();
      n_checks++;
      if ({chip_run, socket_out, Busy} !== {5'b0, 16'h0, 1'b1}) begin
        n_fail++; $display("FAIL invalid_quiet: run=%b sock=%h busy=%b expected 0/0/1", chip_run, socket_out, Busy);
      end
      Ack = 1'b1;
      #1;
      n_checks++;
      if (chip_disp !== 5'b0) begin n_fail++; $display("FAIL invalid_no_disp: got %b expected 0", chip_disp); end
      step();
      Ack = 1'b0;
      step();
      n_checks++;
      if ({Busy, Invalid, Fail} !== 3'b011) begin
        n_fail++; $display("FAIL invalid_release: busy/inv/fail=%b expected 011", {Busy, Invalid, Fail});
      end
    end
    chip_done = '0;
  endtask

`ifdef CHIP_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    chip_done = '0; chip_rslt = '1;
    exp_q.push_back({3'd3, 1'b0, 1'b1, 1'b0, 1'b1});
    exp_runs++;
    Sel = 3'd3; Start = 1'b1;
    step();
    Start = 1'b0;
    step();
    wait_verdict();
    n_checks++;
    if (lat !== TO) begin n_fail++; $display("FAIL timeout_latency: got %0d expected %0d", lat, TO); end
    n_checks++;
    e = exp_q.pop_front();
    if ({cur_sel, Pass, Fail, Invalid, Timeout} !== e) begin
      n_fail++; $display("FAIL timeout_verdict: got %b expected %b", {cur_sel, Pass, Fail, Invalid, Timeout}, e);
    end
    chip_done[3] = 1'b1;
    Ack = 1'b1; exp_disps++;
    #1;
    n_checks++;
    if (chip_disp !== 5'b01000) begin n_fail++; $display("FAIL timeout_disp: got %b expected 01000", chip_disp); end
    step();
    Ack = 1'b0;
    step();
    n_checks++;
    if (Busy !== 1'b0) begin n_fail++; $display("FAIL timeout_release: Busy=%b expected 0", Busy); end
    chip_done = '0;
  endtask
`endif

  task automatic test_reset_midtest();
    chip_done = '0; chip_rslt = 5'b10000; set_pins();
    exp_runs++;
    Sel = 3'd4; Start = 1'b1;
    step(); step(); step();
    Reset = 1'b1;
    step();
    n_checks++;
    if ({chip_run, chip_disp, socket_out, Busy, Pass, Fail, Invalid, Timeout, cur_sel} !== 34'd0) begin
      n_fail++; $display("FAIL reset_midtest: got %h expected 0",
               {chip_run, chip_disp, socket_out, Busy, Pass, Fail, Invalid, Timeout, cur_sel});
    end
    Reset = 1'b0;
    repeat (3) step();
    n_checks++;
    if (Busy !== 1'b0) begin n_fail++; $display("FAIL no_relaunch: Busy=%b expected 0", Busy); end
    Start = 1'b0;
    step();
    Start = 1'b1; exp_runs++;
    exp_q.push_back({3'd4, 1'b1, 1'b0, 1'b0, 1'b0});
    step();
    Start = 1'b0;
    n_checks++;
    if (chip_run !== 5'b10000) begin n_fail++; $display("FAIL relaunch: got %b expected 10000", chip_run); end
    step();
    chip_done[4] = 1'b1;
    wait_verdict();
    n_checks++;
    e = exp_q.pop_front();
    if ({cur_sel, Pass, Fail, Invalid, Timeout} !== e || lat !== 2) begin
      n_fail++; $display("FAIL relaunch_verdict: got %b lat %0d expected %b lat 2",
                         {cur_sel, Pass, Fail, Invalid, Timeout}, lat, e);
    end
    Ack = 1'b1; exp_disps++;
    step();
    Ack = 1'b0;
    chip_done[4] = 1'b0;
    step();
    n_checks++;
    if (Busy !== 1'b0) begin n_fail++; $display("FAIL relaunch_idle: Busy=%b expected 0", Busy); end
  endtask

  task automatic test_one_hot();
    step();
    n_checks++;
    if (multi_hot !== 0) begin n_fail++; $display("FAIL one_hot: got %0d multi-hot cycles expected 0", multi_hot); end
    n_checks++;
    if (run_pulses !== exp_runs) begin n_fail++; $display("FAIL run_count: got %0d expected %0d", run_pulses, exp_runs); end
    n_checks++;
    if (disp_pulses !== exp_disps) begin n_fail++; $display("FAIL disp_count: got %0d expected %0d", disp_pulses, exp_disps); end
    n_checks++;
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL scoreboard_empty: got %0d left expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail();
    test_glitch();
    test_invalid();
`ifdef CHIP_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_midtest();
    test_one_hot();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded 200000 ns");
    $fatal(1, "bench time limit");
  end
endmodule
